// File: rtl/alu_share_arb_pkg.sv
// Shared constants and types for the alu_share_arb slice: FSM state
// encodings, ALU function codes and the condition-code layout.
package alu_share_arb_pkg;

  // Arbiter FSM encodings, kept as plain constants for legacy compatibility
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_EXEC = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  // OPq function codes understood by the shared ALU
  localparam logic [3:0] FUN_ADDQ = 4'h0;
  localparam logic [3:0] FUN_SUBQ = 4'h1;
  localparam logic [3:0] FUN_ANDQ = 4'h2;
  localparam logic [3:0] FUN_XORQ = 4'h3;

  // Condition codes come out of reset as "zero result"
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// 2-way request picker for the shared ALU.
// Macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins a contest (i_last_grant ignored);
// otherwise the port not granted last wins when both request.
module alu_rr_pick
  import alu_share_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // One-hot grant from the current requests
  always_comb begin
    o_grant = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (i_valid[0]) begin
      o_grant = 2'b01;
    end else if (i_valid[1]) begin
      o_grant = 2'b10;
    end
`else
    if (&i_valid) begin
      o_grant = i_last_grant ? 2'b01 : 2'b10;
    end else begin
      o_grant = i_valid;
    end
`endif
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one 64-bit ALU between the execute stage (port 0,
// may update CC) and address generation (port 1, never touches CC).
// One op in flight: IDLE -> EXEC -> RESP -> IDLE. Owns the ZF/SF/OF register.
// Macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (port 0) in alu_rr_pick.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned FUN_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              p0_valid_i,
  output logic              p0_ready_o,
  input  logic [DATA_W-1:0] p0_aluA_i,
  input  logic [DATA_W-1:0] p0_aluB_i,
  input  logic [FUN_W-1:0]  p0_fun_i,
  input  logic              p0_set_cc_i,
  output logic              p0_rvalid_o,
  input  logic              p0_rready_i,
  output logic [DATA_W-1:0] p0_valE_o,
  input  logic              p1_valid_i,
  output logic              p1_ready_o,
  input  logic [DATA_W-1:0] p1_aluA_i,
  input  logic [DATA_W-1:0] p1_aluB_i,
  input  logic [FUN_W-1:0]  p1_fun_i,
  output logic              p1_rvalid_o,
  input  logic              p1_rready_i,
  output logic [DATA_W-1:0] p1_valE_o,
  output logic [2:0]        cc_o,
  output logic              busy_o
);

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_set_cc;
  logic [DATA_W-1:0] r_aluA;
  logic [DATA_W-1:0] r_aluB;
  logic [FUN_W-1:0]  r_fun;
  logic [DATA_W-1:0] r_p0_valE;
  logic [DATA_W-1:0] r_p1_valE;
  cc_t               r_cc;

  logic              w_idle;
  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_p0_flush;
  logic [DATA_W-1:0] w_valE;
  cc_t               w_flags;

  assign w_idle     = (r_state == ARB_IDLE);
  // A flush in IDLE suppresses the port-0 request for that cycle only
  assign w_req      = {p1_valid_i, p0_valid_i & ~flush_i};
  assign w_p0_flush = flush_i & ~r_owner;

  alu_rr_pick u_pick (
    .i_valid      (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign p0_ready_o  = w_idle & w_grant[0];
  assign p1_ready_o  = w_idle & w_grant[1];
  assign p0_rvalid_o = (r_state == ARB_RESP) & ~r_owner & ~flush_i;
  assign p1_rvalid_o = (r_state == ARB_RESP) & r_owner;
  assign p0_valE_o   = r_p0_valE;
  assign p1_valE_o   = r_p1_valE;
  assign cc_o        = r_cc;
  assign busy_o      = ~w_idle;

  // Shared ALU on the latched operands; SUBQ computes B - A (valB - valA)
  always_comb begin
    w_valE     = '0;
    w_flags.of = 1'b0;
    case (r_fun)
      FUN_ADDQ: begin
        w_valE     = r_aluB + r_aluA;
        w_flags.of = (r_aluA[DATA_W-1] == r_aluB[DATA_W-1]) &&
                     (w_valE[DATA_W-1] != r_aluA[DATA_W-1]);
      end
      FUN_SUBQ: begin
        w_valE     = r_aluB - r_aluA;
        w_flags.of = (r_aluA[DATA_W-1] != r_aluB[DATA_W-1]) &&
                     (w_valE[DATA_W-1] != r_aluB[DATA_W-1]);
      end
      FUN_ANDQ: w_valE = r_aluB & r_aluA;
      FUN_XORQ: w_valE = r_aluB ^ r_aluA;
      default:  w_valE = '0;
    endcase
    w_flags.zf = (w_valE == '0);
    w_flags.sf = w_valE[DATA_W-1];
  end

  // Arbiter FSM, operand capture, result and CC registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ARB_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_set_cc     <= 1'b0;
      r_aluA       <= '0;
      r_aluB       <= '0;
      r_fun        <= '0;
      r_p0_valE    <= '0;
      r_p1_valE    <= '0;
      r_cc         <= CC_RESET;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|w_grant) begin
            r_owner      <= w_grant[1];
            r_last_grant <= w_grant[1];
            r_aluA       <= w_grant[1] ? p1_aluA_i : p0_aluA_i;
            r_aluB       <= w_grant[1] ? p1_aluB_i : p0_aluB_i;
            r_fun        <= w_grant[1] ? p1_fun_i  : p0_fun_i;
            r_set_cc     <= w_grant[0] & p0_set_cc_i;
            r_state      <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          if (w_p0_flush) begin
            r_state <= ARB_IDLE;
          end else begin
            if (r_owner) begin
              r_p1_valE <= w_valE;
            end else begin
              r_p0_valE <= w_valE;
              if (r_set_cc) begin
                r_cc <= w_flags;
              end
            end
            r_state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (w_p0_flush) begin
            r_state <= ARB_IDLE;
          end else if (r_owner ? p1_rready_i : p0_rready_i) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
